// File: rtl/line_sweep_controller.sv
// line_sweep_controller
//   Sequences the line drawer so a radial line from the fixed point (CX,CY)
//   sweeps clockwise around a rectangle. Each step draws the line, holds it
//   for HOLD_CYCLES, erases it, then advances the far endpoint along the
//   rectangle perimeter by STEP pixels.
//
// Ports
//   clk     system clock (CLOCK_50 domain)
//   reset   synchronous, active-high
//   enable  run request, level-sensitive; dropping it lets the current
//           draw/hold/erase finish and advance before going idle
//   done    drawer finished the current line
//   start   one-cycle pulse: drawer latches endpoints and begins
//   x0,y0   near endpoint, constant (CX,CY)
//   x1,y1   far endpoint on the rectangle perimeter
//   color   1 = draw, 0 = erase
//   busy    high whenever the sequencer is not idle
//   laps    completed perimeter circuits, wraps 255 -> 0
module line_sweep_controller #(
    parameter int CX          = 320,
    parameter int CY          = 240,
    parameter int LEFT        = 160,
    parameter int RIGHT       = 480,
    parameter int TOP         = 80,
    parameter int BOTTOM      = 400,
    parameter int STEP        = 8,
    parameter int HOLD_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       done,
    output logic       start,
    output logic [9:0] x0,
    output logic [8:0] y0,
    output logic [9:0] x1,
    output logic [8:0] y1,
    output logic       color,
    output logic       busy,
    output logic [7:0] laps
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE, DRAW_START, DRAW_WAIT, HOLD, ERASE_START, ERASE_WAIT, ADVANCE
    } state_t;

    typedef enum logic [1:0] {
        TOP_EDGE, RIGHT_EDGE, BOTTOM_EDGE, LEFT_EDGE
    } side_t;

    state_t        state, state_n;
    side_t         side, side_n;
    logic [HW-1:0] hold_cnt;
    logic          wait_first;   // first WAIT cycle: done may still be left over from the previous line
    logic [9:0]    x1_n;
    logic [8:0]    y1_n;
    logic          lap_inc;

    // Widened by one bit so stepping past the bounds never wraps.
    logic [10:0] x_up;
    logic [9:0]  y_up;
    assign x_up = {1'b0, x1} + 11'(STEP);
    assign y_up = {1'b0, y1} + 10'(STEP);

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:        if (enable) state_n = DRAW_START;
            DRAW_START:  state_n = DRAW_WAIT;
            DRAW_WAIT:   if (done && !wait_first) state_n = HOLD;
            HOLD:        if (hold_cnt == '0) state_n = ERASE_START;
            ERASE_START: state_n = ERASE_WAIT;
            ERASE_WAIT:  if (done && !wait_first) state_n = ADVANCE;
            ADVANCE:     state_n = enable ? DRAW_START : IDLE;
            default:     state_n = IDLE;
        endcase
    end

    // Perimeter walk: next far endpoint, applied only in ADVANCE.
    // Reaching or passing a corner clamps to it and turns the corner.
    always_comb begin
        x1_n    = x1;
        y1_n    = y1;
        side_n  = side;
        lap_inc = 1'b0;
        case (side)
            TOP_EDGE: begin
                if (x_up >= 11'(RIGHT)) begin
                    x1_n   = 10'(RIGHT);
                    side_n = RIGHT_EDGE;
                end else begin
                    x1_n = x_up[9:0];
                end
            end
            RIGHT_EDGE: begin
                if (y_up >= 10'(BOTTOM)) begin
                    y1_n   = 9'(BOTTOM);
                    side_n = BOTTOM_EDGE;
                end else begin
                    y1_n = y_up[8:0];
                end
            end
            BOTTOM_EDGE: begin
                // x1 - STEP <= LEFT, rearranged so it cannot underflow
                if ({1'b0, x1} <= 11'(LEFT + STEP)) begin
                    x1_n   = 10'(LEFT);
                    side_n = LEFT_EDGE;
                end else begin
                    x1_n = x1 - 10'(STEP);
                end
            end
            default: begin
                if ({1'b0, y1} <= 10'(TOP + STEP)) begin
                    y1_n    = 9'(TOP);
                    side_n  = TOP_EDGE;
                    lap_inc = 1'b1;
                end else begin
                    y1_n = y1 - 9'(STEP);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            side       <= TOP_EDGE;
            start      <= 1'b0;
            color      <= 1'b0;
            busy       <= 1'b0;
            laps       <= 8'd0;
            x0         <= 10'(CX);
            y0         <= 9'(CY);
            x1         <= 10'(LEFT);
            y1         <= 9'(TOP);
            hold_cnt   <= '0;
            wait_first <= 1'b0;
        end else begin
            state      <= state_n;
            x0         <= 10'(CX);
            y0         <= 9'(CY);
            // Outputs are decoded from next state so they line up with the state register.
            start      <= (state_n == DRAW_START) || (state_n == ERASE_START);
            busy       <= (state_n != IDLE);
            wait_first <= (state == DRAW_START) || (state == ERASE_START);
            if (state_n == DRAW_START)
                color <= 1'b1;
            else if (state_n == ERASE_START)
                color <= 1'b0;

            if (state == DRAW_WAIT && state_n == HOLD)
                hold_cnt <= HW'(HOLD_CYCLES - 1);
            else if (state == HOLD && hold_cnt != '0)
                hold_cnt <= hold_cnt - 1'b1;

            // Endpoint only moves after the erase, so x1/y1 stay put across
            // the whole draw/hold/erase of one step.
            if (state == ADVANCE) begin
                x1   <= x1_n;
                y1   <= y1_n;
                side <= side_n;
                if (lap_inc)
                    laps <= laps + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_line_sweep_controller.sv
// Testbench for line_sweep_controller on a small box (10..30 x 10..25,
// STEP 8, HOLD 4). Expected draw/erase records are queued by the stimulus
// tasks; a monitor pops one per start pulse and checks endpoints, colour,
// laps and the cycle spacing between start pulses.
module tb_line_sweep_controller;

    localparam int L = 10, R = 30, T = 10, B = 25, S = 8, HC = 4;
    localparam int CXV = 320, CYV = 240;

    logic       clk = 1'b0;
    logic       reset, enable, done;
    logic       start, color, busy;
    logic [9:0] x0, x1;
    logic [8:0] y0, y1;
    logic [7:0] laps;

    always #5 clk = ~clk;

    line_sweep_controller #(
        .CX(CXV), .CY(CYV), .LEFT(L), .RIGHT(R), .TOP(T), .BOTTOM(B),
        .STEP(S), .HOLD_CYCLES(HC)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .done(done),
        .start(start), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
        .color(color), .busy(busy), .laps(laps)
    );

    typedef struct {
        bit color;
        int x;
        int y;
        int laps;
        bit first;
        int exp_cyc;
    } exp_t;

    exp_t q[$];
    int   px[$], py[$];
    int   nlap;
    int   n_tests = 0, n_fail = 0;
    int   g = 0;          // perimeter steps completed since reset
    int   n_draws = 0;
    int   mode = 0;       // done behaviour: 0 fixed 5, 1 held high, 2 random
    int   last_r = 0;     // cycles from latest start to accepted done
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One lap of far-endpoint positions, described as offsets k*STEP along
    // each side, stopping at the corner that starts the next side.
    task automatic build_lap();
        for (int k = 0; k * S < R - L; k++) begin px.push_back(L + k * S); py.push_back(T); end
        for (int k = 0; k * S < B - T; k++) begin px.push_back(R); py.push_back(T + k * S); end
        for (int k = 0; k * S < R - L; k++) begin px.push_back(R - k * S); py.push_back(B); end
        for (int k = 0; k * S < B - T; k++) begin px.push_back(L); py.push_back(B - k * S); end
        nlap = px.size();
    endtask

    function automatic exp_t mk(bit c, int idx, bit f, int ec);
        exp_t e;
        e.color   = c;
        e.x       = px[idx % nlap];
        e.y       = py[idx % nlap];
        e.laps    = (idx / nlap) % 256;
        e.first   = f;
        e.exp_cyc = ec;
        return e;
    endfunction

    // Drawer model: answers each start with done after a delay.
    initial begin
        int dcnt, r;
        bit stale;
        dcnt = 0; r = 0; stale = 0;
        done = 1'b0;
        forever begin
            @(negedge clk);
            done = 1'b0;
            if (reset === 1'b1) dcnt = 0;
            if (mode == 1) begin
                done = 1'b1;
                if (start === 1'b1) last_r = 2;
            end else if (start === 1'b1) begin
                r      = (mode == 0) ? 5 : $urandom_range(2, 9);
                dcnt   = r;
                last_r = r;
                stale  = (mode == 2) && ($urandom_range(0, 1) == 1);
            end else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) done = 1'b1;
                else if (stale && dcnt == r - 1) done = 1'b1;   // lands in the first WAIT cycle
            end else if (mode == 2 && $urandom_range(0, 3) == 0) begin
                done = 1'b1;                                    // noise outside any WAIT
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        bit   prev_v, prev_c, prev_s;
        int   prev_cyc;
        exp_t e;
        prev_v = 0; prev_c = 0; prev_s = 0; prev_cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset !== 1'b0) begin
                prev_v = 0;
                prev_s = 0;
            end else begin
                if (start === 1'b1) begin
                    check("start_back_to_back", int'(prev_s), 0);
                    if (q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_start: start at cycle %0d with x1=%0d y1=%0d color=%0d",
                                 cyc, x1, y1, color);
                    end else begin
                        e = q.pop_front();
                        check("color", int'(color), int'(e.color));
                        check("x1", int'(x1), e.x);
                        check("y1", int'(y1), e.y);
                        check("laps", int'(laps), e.laps);
                        check("x0", int'(x0), CXV);
                        check("y0", int'(y0), CYV);
                        check("busy_at_start", int'(busy), 1);
                        if (e.first)
                            check("first_start_cycle", cyc, e.exp_cyc);
                        else if (prev_v)
                            check("start_gap", cyc - prev_cyc, prev_c ? last_r + HC + 1 : last_r + 2);
                        prev_c = e.color;
                    end
                    prev_v   = 1;
                    prev_cyc = cyc;
                    if (color === 1'b1) n_draws++;
                end
                prev_s = (start === 1'b1);
            end
        end
    end

    // Run n steps, then drop enable d cycles after the last draw start
    // (d < 0: random 0..8, always before that step's ADVANCE).
    task automatic run(int n, int m, int drop);
        int tgt, d, waited;
        @(negedge clk);
        mode = m;
        for (int i = 0; i < n; i++) begin
            q.push_back(mk(1'b1, g + i, (i == 0), cyc + 1));
            q.push_back(mk(1'b0, g + i, 1'b0, 0));
        end
        tgt    = n_draws + n;
        enable = 1'b1;
        waited = 0;
        while (n_draws < tgt && waited < n * 40 + 100) begin
            @(negedge clk);
            waited++;
        end
        check("run_draw_count", n_draws, tgt);
        d = (drop < 0) ? $urandom_range(0, 8) : drop;
        repeat (d) @(negedge clk);
        enable = 1'b0;
        waited = 0;
        while (busy !== 1'b0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        check("idle_busy", int'(busy), 0);
        g += n;
        repeat (20) @(negedge clk);
        check("idle_queue_empty", q.size(), 0);
        check("idle_busy_stays_low", int'(busy), 0);
        check("idle_x1", int'(x1), px[g % nlap]);
        check("idle_y1", int'(y1), py[g % nlap]);
        check("idle_laps", int'(laps), (g / nlap) % 256);
        check("idle_color", int'(color), 0);
    endtask

    // Reset while the drawer is still busy with a draw.
    task automatic reset_mid();
        int tgt, waited;
        @(negedge clk);
        mode = 0;
        q.push_back(mk(1'b1, g, 1'b1, cyc + 1));
        tgt    = n_draws + 1;
        enable = 1'b1;
        waited = 0;
        while (n_draws < tgt && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("rst_mid_draw_seen", n_draws, tgt);
        check("rst_mid_laps_before", int'(laps), (g / nlap) % 256);
        repeat (2) @(negedge clk);      // DRAW_WAIT, done not yet returned
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_start", int'(start), 0);
        check("rst_mid_color", int'(color), 0);
        check("rst_mid_x1", int'(x1), L);
        check("rst_mid_y1", int'(y1), T);
        check("rst_mid_laps", int'(laps), 0);
        reset = 1'b0;
        q.delete();
        g = 0;
        repeat (10) @(negedge clk);
        check("rst_mid_stays_idle", int'(busy), 0);
    endtask

    initial begin
        build_lap();
        reset  = 1'b1;
        enable = 1'b1;       // reset must win over enable
        repeat (3) @(negedge clk);
        check("rst_wins_busy", int'(busy), 0);
        check("rst_wins_start", int'(start), 0);
        enable = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        check("rst_start", int'(start), 0);
        check("rst_color", int'(color), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_laps", int'(laps), 0);
        check("rst_x1", int'(x1), L);
        check("rst_y1", int'(y1), T);
        check("rst_x0", int'(x0), CXV);
        check("rst_y0", int'(y0), CYV);
        check("lap_length", nlap, 10);

        run(1, 0, 7);          // first draw, enable dropped during HOLD
        run(12, 0, -1);        // continues round the corners and into lap 2
        run(20, 2, -1);        // random done latency plus stray done pulses
        reset_mid();
        run(2565, 1, -1);      // done held high; laps passes 255 -> 0
        run(15, 2, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
